quad_decoder_counter: RTL and testbench

Quadrature decoder feeding an up/down position counter. It is the receive/decode side of a two-phase A/B encoder interface.
- Synchronises asynchronous A/B phase inputs into clk.
- Decodes each legal Gray-code step as up or down.
- Keeps a WIDTH-bit wrap-around position count with direction, step, overflow and error flags.
- Used as a position/step tracker in front of control logic.

---
 rtl/quad_decoder_counter.sv | 139 +++++++++++++
 tb/tb_quad_decoder_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_counter.sv
// Quadrature A/B decoder driving a WIDTH-bit wrap-around up/down position counter.
// Optional per-phase glitch filter enabled with `define GLITCH_FILTER_EN.
module quad_decoder_counter #(
    parameter int WIDTH    = 8,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic             a_in,
    input  logic             b_in,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             ovf,
    output logic             err,
    output logic             err_sticky
);

    // Cycles from reset release until the decode input reflects the pins.
`ifdef GLITCH_FILTER_EN
    localparam int SETTLE = 2 + FILT_LEN;
`else
    localparam int SETTLE = 2;
`endif
    localparam int SW = $clog2(2 + FILT_LEN + 1);

    logic [1:0]    a_sync, b_sync;
    logic          a_cur, b_cur;
    logic [1:0]    cur, prev;
    logic          init;
    logic [SW-1:0] settle;
    logic          up, dn, bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
        end else begin
            a_sync <= {a_sync[0], a_in};
            b_sync <= {b_sync[0], b_in};
        end
    end

`ifdef GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] a_cnt, b_cnt;
    logic          a_filt, b_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt  <= '0;
            b_cnt  <= '0;
            a_filt <= 1'b0;
            b_filt <= 1'b0;
        end else begin
            if (a_sync[1] == a_filt)
                a_cnt <= '0;
            else if (a_cnt == CW'(FILT_LEN - 1)) begin
                a_filt <= a_sync[1];
                a_cnt  <= '0;
            end else
                a_cnt <= a_cnt + 1'b1;

            if (b_sync[1] == b_filt)
                b_cnt <= '0;
            else if (b_cnt == CW'(FILT_LEN - 1)) begin
                b_filt <= b_sync[1];
                b_cnt  <= '0;
            end else
                b_cnt <= b_cnt + 1'b1;
        end
    end

    assign a_cur = a_filt;
    assign b_cur = b_filt;
`else
    assign a_cur = a_sync[1];
    assign b_cur = b_sync[1];
`endif

    assign cur = {a_cur, b_cur};

    always_comb begin
        up  = 1'b0;
        dn  = 1'b0;
        bad = ((cur ^ prev) == 2'b11);
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dn = 1'b1;
            default: ;
        endcase
    end

    // Decode stays off until the reset value has flushed out of the
    // synchroniser (and filter), so a resting 11 is never seen as 00->11.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= 2'b00;
            init       <= 1'b0;
            settle     <= '0;
            count      <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            ovf        <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            step <= 1'b0;
            ovf  <= 1'b0;
            err  <= 1'b0;
            prev <= cur;
            if (!init) begin
                if (settle == SW'(SETTLE))
                    init <= 1'b1;
                else
                    settle <= settle + 1'b1;
            end else begin
                if (bad) begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                end
                if (ena && !clr && (up || dn)) begin
                    count <= up ? count + 1'b1 : count - 1'b1;
                    dir   <= up;
                    step  <= 1'b1;
                    ovf   <= up ? (&count) : ~(|count);
                end
            end
            if (clr) begin
                count      <= '0;
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed table-driven bench for quad_decoder_counter, plus hand sequences
// for latency, clr priority, reset mid-operation and the optional filter.
module tb_quad_decoder_counter;

    localparam int W = 8;
`ifdef GLITCH_FILTER_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif
    localparam int LAT  = 3 + FL;
    localparam int HOLD = LAT + 6;

    logic         clk = 1'b0;
    logic         rst, ena, clr, a, b;
    logic [W-1:0] count;
    logic         dir, step, ovf, err, err_sticky;

    quad_decoder_counter #(.WIDTH(W), .FILT_LEN(4)) dut (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .a_in(a), .b_in(b),
        .count(count), .dir(dir), .step(step), .ovf(ovf), .err(err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ab;
        logic       en;
        logic       cl;
        int         cnt;
        logic       d;
        int         st;
        int         ov;
        int         er;
        logic       sk;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] ab, input logic en, input logic cl,
                                input int cnt, input logic d, input int st, input int ov,
                                input int er, input logic sk);
        vec_t v;
        v.ab = ab; v.en = en; v.cl = cl; v.cnt = cnt; v.d = d;
        v.st = st; v.ov = ov; v.er = er; v.sk = sk;
        return v;
    endfunction

    // Drive one record, hold HOLD cycles counting pulses, then compare.
    task automatic run_vec(input string tag, input vec_t v);
        int ns, no, ne;
        ns = 0; no = 0; ne = 0;
        a = v.ab[1]; b = v.ab[0]; ena = v.en; clr = v.cl;
        for (int i = 0; i < HOLD; i++) begin
            @(posedge clk); #1;
            clr = 1'b0;
            ns += int'(step); no += int'(ovf); ne += int'(err);
        end
        chk({tag, " count"}, 32'(count), 32'(v.cnt));
        chk({tag, " dir"}, 32'(dir), 32'(v.d));
        chk({tag, " steps"}, 32'(ns), 32'(v.st));
        chk({tag, " ovfs"}, 32'(no), 32'(v.ov));
        chk({tag, " errs"}, 32'(ne), 32'(v.er));
        chk({tag, " sticky"}, 32'(err_sticky), 32'(v.sk));
    endtask

    // Change AB and assert clr for exactly the cycle the step would land.
    task automatic drive_with_clr(input logic [1:0] ab);
        a = ab[1]; b = ab[0];
        repeat (LAT - 1) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int ns;
        rst = 1'b1; ena = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0;

        tbl.push_back(mk(2'b00, 1, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 1, 0,   1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2'b11, 1, 0,   2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2'b01, 1, 0,   3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2'b00, 1, 0,   4, 1, 1, 0, 0, 0));
        tbl.push_back(mk(2'b01, 1, 0,   3, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2'b11, 1, 0,   2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2'b10, 1, 0,   1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2'b00, 1, 0,   0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2'b01, 1, 0, 255, 0, 1, 1, 0, 0));
        tbl.push_back(mk(2'b11, 1, 0, 254, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2'b10, 1, 0, 253, 0, 1, 0, 0, 0));
        tbl.push_back(mk(2'b01, 1, 0, 253, 0, 0, 0, 1, 1));
        tbl.push_back(mk(2'b01, 1, 1,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 1, 0,   1, 1, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(count), 32'd0);
        chk("reset dir", 32'(dir), 32'd0);
        chk("reset step", 32'(step), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset sticky", 32'(err_sticky), 32'd0);
        rst = 1'b0;
        repeat (HOLD) @(posedge clk);
        #1;

        foreach (tbl[i]) run_vec($sformatf("v%0d", i), tbl[i]);

        // Latency: change just after edge 0, count moves after edge LAT only.
        a = 1'b1; b = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat count e%0d", k), 32'(count), (k < LAT) ? 32'd1 : 32'd2);
            chk($sformatf("lat step e%0d", k), 32'(step), (k < LAT) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        chk("lat step width", 32'(step), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // clr coinciding with an up step: step lost, dir untouched.
        drive_with_clr(2'b11);
        chk("clr+step count", 32'(count), 32'd0);
        chk("clr+step step", 32'(step), 32'd0);
        chk("clr+step ovf", 32'(ovf), 32'd0);
        clr = 1'b0;
        ns = 0;
        repeat (4) begin
            @(posedge clk); #1;
            ns += int'(step);
        end
        chk("clr+step late steps", 32'(ns), 32'd0);
        chk("clr+step dir", 32'(dir), 32'd1);

        // Error coinciding with clr: err pulses, sticky stays clear.
        drive_with_clr(2'b00);
        chk("clr+err err", 32'(err), 32'd1);
        chk("clr+err sticky", 32'(err_sticky), 32'd0);
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("clr+err sticky later", 32'(err_sticky), 32'd0);

        run_vec("pre-rst err", mk(2'b11, 1, 0, 0, 1, 0, 0, 1, 1));
        run_vec("pre-rst up", mk(2'b01, 1, 0, 1, 1, 1, 0, 0, 1));

        // Reset mid-operation with inputs parked at 11 across release.
        a = 1'b1; b = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid-rst count", 32'(count), 32'd0);
        chk("mid-rst dir", 32'(dir), 32'd0);
        chk("mid-rst sticky", 32'(err_sticky), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_vec("post-rst 11", mk(2'b11, 1, 0, 0, 0, 0, 0, 0, 0));
        run_vec("post-rst down", mk(2'b10, 1, 0, 255, 0, 1, 1, 0, 0));

`ifdef GLITCH_FILTER_EN
        // A 2-cycle dip on A must be filtered out completely.
        a = 1'b0;
        repeat (2) @(posedge clk);
        #1 a = 1'b1;
        run_vec("glitch", mk(2'b10, 1, 0, 255, 0, 0, 0, 0, 0));
        run_vec("filt stable", mk(2'b00, 1, 0, 254, 0, 1, 0, 0, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
